can_bus_arbiter: RTL and testbench

CAN_BUS_ARBITER -- requirements
Module: can_bus_arbiter

---
 rtl/can_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_can_bus_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/can_bus_arbiter.sv
// CAN-style bitwise bus arbiter: snapshots requests, resolves MSB-first
// on identifiers, holds the bus for one frame, then an inter-frame gap.
module can_bus_arbiter #(
  parameter int N         = 4,
  parameter int FRAME_MAX = 32,
  parameter int IFS_LEN   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] id,
  output logic           bus_bit,
  output logic [N-1:0]   grant,
  output logic [7:0]     win_id,
  output logic           busy,
  output logic [N-1:0]   lost,
  output logic           dup_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(FRAME_MAX + 1);
  localparam int SW = $clog2(IFS_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_BUSY,
    S_IFS
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   cont_q, cont_d;
  logic [8*N-1:0] ids_q, ids_d;
  logic [2:0]     bit_q, bit_d;
  logic [N-1:0]   lost_q, lost_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [7:0]     win_id_q, win_id_d;
  logic [IW-1:0]  win_q, win_d;
  logic [FW-1:0]  fcnt_q, fcnt_d;
  logic [SW-1:0]  icnt_q, icnt_d;
  logic           dup_q, dup_d;

  logic [N-1:0]   cur;
  logic           arb_bus;
  logic [N-1:0]   drop;
  logic [N-1:0]   surv;
  logic [N-1:0]   first_oh;
  logic [IW-1:0]  first;
  logic           multi;

  always_comb begin
    cur = '0;
    for (int i = 0; i < N; i++) begin
      cur[i] = ids_q[8*i + int'(bit_q)];
    end
  end

  // Wired-AND: idle (non-contending) nodes read as recessive.
  assign arb_bus  = &(cur | ~cont_q);
  assign drop     = arb_bus ? '0 : (cont_q & cur);
  assign surv     = cont_q & ~drop;
  assign first_oh = surv & ~(surv - N'(1));

  always_comb begin
    int cnt;
    first = '0;
    cnt   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (surv[i]) begin
        first = IW'(i);
        cnt   = cnt + 1;
      end
    end
    multi = (cnt > 1);
  end

  always_comb begin
    state_d  = state_q;
    cont_d   = cont_q;
    ids_d    = ids_q;
    bit_d    = bit_q;
    lost_d   = lost_q;
    grant_d  = grant_q;
    win_id_d = win_id_q;
    win_d    = win_q;
    fcnt_d   = fcnt_q;
    icnt_d   = icnt_q;
    dup_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          cont_d  = req;
          ids_d   = id;
          bit_d   = 3'd7;
          lost_d  = '0;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        cont_d = surv;
        lost_d = lost_q | drop;
        if (bit_q == 3'd0) begin
          state_d  = S_BUSY;
          grant_d  = first_oh;
          win_d    = first;
          win_id_d = ids_q[{first, 3'b000} +: 8];
          fcnt_d   = '0;
          dup_d    = multi;
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end
      S_BUSY: begin
        if (!req[win_q] ||
            fcnt_q == FW'(FRAME_MAX - 1)) begin
          state_d = S_IFS;
          grant_d = '0;
          icnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      S_IFS: begin
        if (icnt_q == SW'(IFS_LEN - 1)) begin
          state_d = S_IDLE;
        end else begin
          icnt_d = icnt_q + SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cont_q   <= '0;
      ids_q    <= '0;
      bit_q    <= '0;
      lost_q   <= '0;
      grant_q  <= '0;
      win_id_q <= '0;
      win_q    <= '0;
      fcnt_q   <= '0;
      icnt_q   <= '0;
      dup_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cont_q   <= cont_d;
      ids_q    <= ids_d;
      bit_q    <= bit_d;
      lost_q   <= lost_d;
      grant_q  <= grant_d;
      win_id_q <= win_id_d;
      win_q    <= win_d;
      fcnt_q   <= fcnt_d;
      icnt_q   <= icnt_d;
      dup_q    <= dup_d;
    end
  end

  assign bus_bit = (state_q == S_ARB)  ? arb_bus :
                   (state_q == S_BUSY) ? 1'b0 : 1'b1;
  assign busy    = (state_q != S_IDLE);
  assign grant   = grant_q;
  assign win_id  = win_id_q;
  assign lost    = lost_q;
  assign dup_err = dup_q;

endmodule

// File: tb/tb_can_bus_arbiter.sv
// Directed bench for can_bus_arbiter: vector table plus
// timeout, release, snapshot and reset sequences.
module tb_can_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] id;
  logic        bus_bit;
  logic [3:0]  grant;
  logic [7:0]  win_id;
  logic        busy;
  logic [3:0]  lost;
  logic        dup_err;

  int ncmp;
  int nerr;

  can_bus_arbiter #(
    .N(4),
    .FRAME_MAX(32),
    .IFS_LEN(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .id(id),
    .bus_bit(bus_bit),
    .grant(grant),
    .win_id(win_id),
    .busy(busy),
    .lost(lost),
    .dup_err(dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] ids;
    logic [3:0]  grant;
    logic [3:0]  lost;
    logic [7:0]  win;
    logic        dup;
    logic [7:0]  seq;
  } vec_t;

  vec_t v[5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Start from an IDLE negedge; returns #1 after the grant edge.
  task automatic arb(input logic [3:0] r,
                     input logic [31:0] ids,
                     input logic [3:0] eg,
                     input logic [3:0] el,
                     input logic [7:0] ew,
                     input logic ed,
                     input logic [7:0] es,
                     input string nm);
    logic [7:0] seq;
    req = r;
    id  = ids;
    @(posedge clk);
    #1 chk({nm, ".busy"}, 32'(busy), 32'd1);
    for (int b = 7; b >= 0; b--) begin
      @(negedge clk);
      seq[b] = bus_bit;
      if (b == 0) chk({nm, ".nogrant"}, 32'(grant), 0);
      @(posedge clk);
    end
    #1;
    chk({nm, ".grant"}, 32'(grant), 32'(eg));
    chk({nm, ".lost"}, 32'(lost), 32'(el));
    chk({nm, ".win_id"}, 32'(win_id), 32'(ew));
    chk({nm, ".dup"}, 32'(dup_err), 32'(ed));
    chk({nm, ".busseq"}, 32'(seq), 32'(es));
  endtask

  task automatic count_grant(input int rel,
                             output int cnt);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (grant == 4'd0) break;
      cnt++;
      if (cnt == 2) chk("dup_pulse", 32'(dup_err), 0);
      if (cnt == rel) req = 4'd0;
    end
  endtask

  task automatic wait_idle(input string nm);
    req = 4'd0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({nm, ".idle"}, 32'(busy), 0);
  endtask

  initial begin
    int c;
    int n;
    ncmp = 0;
    nerr = 0;
    rst  = 1'b0;
    req  = 4'd0;
    id   = 32'd0;

    v[0] = '{4'b0100, 32'h00350000, 4'b0100,
             4'b0000, 8'h35, 1'b0, 8'h35};
    v[1] = '{4'b1111, 32'hFF706465, 4'b0010,
             4'b1101, 8'h64, 1'b0, 8'h64};
    v[2] = '{4'b1010, 32'h22002200, 4'b0010,
             4'b0000, 8'h22, 1'b1, 8'h22};
    v[3] = '{4'b1000, 32'h00AAAAAA, 4'b1000,
             4'b0000, 8'h00, 1'b0, 8'h00};
    v[4] = '{4'b0011, 32'h00007F80, 4'b0010,
             4'b0001, 8'h7F, 1'b0, 8'h7F};

    #2;
    chk("rst.grant", 32'(grant), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.bus", 32'(bus_bit), 1);
    chk("rst.win_id", 32'(win_id), 0);
    chk("rst.lost", 32'(lost), 0);
    chk("rst.dup", 32'(dup_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      arb(v[i].req, v[i].ids, v[i].grant, v[i].lost,
          v[i].win, v[i].dup, v[i].seq,
          $sformatf("vec%0d", i));
      count_grant(3, c);
      chk($sformatf("vec%0d.len", i), c, 3);
      wait_idle($sformatf("vec%0d", i));
    end
    chk("hold.win_id", 32'(win_id), 32'h7F);
    chk("hold.lost", 32'(lost), 32'b0001);

    arb(4'b0001, 32'h00000010, 4'b0001, 4'b0000,
        8'h10, 1'b0, 8'h10, "tmo");
    count_grant(1000, c);
    chk("tmo.len", c, 32);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy && grant == 4'd0 && bus_bit) n++;
      else break;
      @(negedge clk);
    end
    chk("tmo.ifs", n, 3);
    chk("tmo.idle", 32'(busy), 0);
    repeat (8) @(posedge clk);
    #1 chk("tmo.early", 32'(grant), 0);
    @(posedge clk);
    #1 chk("tmo.regrant", 32'(grant), 32'b0001);
    count_grant(5, c);
    chk("rel.len", c, 5);
    wait_idle("rel");

    req = 4'b0001;
    id  = 32'h01000040;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 req = 4'b1001;
    repeat (6) @(posedge clk);
    #1;
    chk("snap.grant", 32'(grant), 32'b0001);
    chk("snap.lost", 32'(lost), 0);
    chk("snap.win_id", 32'(win_id), 32'h40);
    @(posedge clk);
    #1 req = 4'b1000;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (grant == 4'b1000) break;
    end
    chk("snap.next", 32'(grant), 32'b1000);
    chk("snap.next_id", 32'(win_id), 32'h01);
    chk("snap.next_lost", 32'(lost), 0);
    wait_idle("snap");

    arb(4'b0100, 32'h00350000, 4'b0100, 4'b0000,
        8'h35, 1'b0, 8'h35, "rstb");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rstb.grant", 32'(grant), 0);
    chk("rstb.busy", 32'(busy), 0);
    chk("rstb.bus", 32'(bus_bit), 1);
    chk("rstb.win_id", 32'(win_id), 0);
    chk("rstb.lost", 32'(lost), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstb.regrant", 32'(grant), 0);
    chk("rstb.reeval", 32'(busy), 1);
    wait_idle("rstb");

    req = 4'b0001;
    id  = 32'h00000010;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    req = 4'd0;
    #1;
    chk("rsta.busy", 32'(busy), 0);
    chk("rsta.bus", 32'(bus_bit), 1);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (grant != 4'd0) n++;
    end
    chk("rsta.nopulse", n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
